// File: rtl/cmd_mem_reader_pkg.sv
// -----------------------------------------------------------------------------
// cmd_mem_reader_pkg
// Shared command-memory definitions for the AT-command reader:
//   - cmd_tx_state_t : 3-bit FSM state type plus its state constants
//   - cmd_tx_error_t : completion status reported with done
//   - ASCII constants used when walking and framing a stored command
// Optional macro: CMD_MEM_READER_ADDR_PREFIX_EN adds the ST_PREFIX state.
// -----------------------------------------------------------------------------
package cmd_mem_reader_pkg;

  typedef logic [2:0] cmd_tx_state_t;

  localparam cmd_tx_state_t ST_IDLE     = 3'd0;
  localparam cmd_tx_state_t ST_CHECK    = 3'd1;
  localparam cmd_tx_state_t ST_RD_ISSUE = 3'd2;
  localparam cmd_tx_state_t ST_RD_WAIT  = 3'd3;
  localparam cmd_tx_state_t ST_SEND     = 3'd4;
  localparam cmd_tx_state_t ST_DONE     = 3'd5;
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
  localparam cmd_tx_state_t ST_PREFIX   = 3'd6;
`endif

  typedef enum logic [1:0] {
    NO_ERR    = 2'd0,  // LF reached
    ERR_ADDR  = 2'd1,  // slot index out of range
    ERR_EMPTY = 2'd2,  // NUL byte read before LF
    ERR_LEN   = 2'd3   // slot exhausted without LF
  } cmd_tx_error_t;

  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_SP  = 8'h20;
  localparam logic [7:0] CHAR_NUL = 8'h00;

endpackage

// File: rtl/cmd_mem_reader_if.sv
// -----------------------------------------------------------------------------
// cmd_mem_reader_if
// Bundles the two data paths of the reader:
//   - command memory read port : mem_rd_en, mem_rd_addr -> mem_rd_data (1-cycle)
//   - UART TX byte stream      : tx_data, tx_valid <- tx_ready
// modport master : the reader (drives strobe/address and the TX byte)
// modport slave  : memory + UART side
// -----------------------------------------------------------------------------
interface cmd_mem_reader_if #(
  parameter int MEM_AW = 10
);
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_rd_en, mem_rd_addr, tx_data, tx_valid,
    input  mem_rd_data, tx_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, tx_data, tx_valid,
    output mem_rd_data, tx_ready
  );
endinterface

// File: rtl/cmd_mem_reader_nibble_to_ascii.sv
// -----------------------------------------------------------------------------
// nibble_to_ascii
// Combinational 4-bit to uppercase ASCII hex digit ('0'-'9', 'A'-'F').
// Ports: nibble (in, 4) ; ascii (out, 8)
// -----------------------------------------------------------------------------
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      // 'A' (0x41) minus 10
      ascii = 8'h37 + {4'h0, nibble};
    end
  end
endmodule

// File: rtl/cmd_mem_reader.sv
// -----------------------------------------------------------------------------
// cmd_mem_reader
// Streams one stored AT command (slot cmd_idx) from the command memory to the
// UART TX, byte by byte, up to and including the terminating LF.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, cmd_idx    : request to send slot cmd_idx (accepted only when idle)
//   busy              : request in progress (CHECK through DONE)
//   done              : one-cycle completion pulse (also for errored requests)
//   error             : cmd_tx_error_t, valid with done, held until next start
//   bus (master)      : memory read port and UART TX byte handshake
//
// Optional macro: CMD_MEM_READER_ADDR_PREFIX_EN -- precede the command with the
// slot index as two uppercase hex digits and a space, e.g. "0A AT\r\n".
// -----------------------------------------------------------------------------
module cmd_mem_reader
  import cmd_mem_reader_pkg::*;
#(
  parameter int NUM_CMDS = 16,
  parameter int IDX_W    = 5,
  parameter int MAX_LEN  = 32,
  parameter int MEM_AW   = IDX_W + $clog2(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_W-1:0]      cmd_idx,
  output logic                  busy,
  output logic                  done,
  output cmd_tx_error_t         error,
  cmd_mem_reader_if.master      bus
);

  localparam int OFF_W = $clog2(MAX_LEN);
  // One extra bit so NUM_CMDS == 2**IDX_W still compares correctly.
  localparam logic [IDX_W:0] NUM_CMDS_W = NUM_CMDS[IDX_W:0];

  cmd_tx_state_t     state_q,    state_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [OFF_W-1:0]  offset_q,   offset_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  cmd_tx_error_t     error_q,    error_d;
  logic              xfer;

`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
  logic [1:0] pfx_cnt_q, pfx_cnt_d;
  logic [7:0] idx_byte;
  logic [7:0] hex_char [2];  // [1] = high nibble digit, [0] = low

  // Indices wider than a byte are reduced to their low 8 bits.
  if (IDX_W >= 8) begin : g_idx_wide
    assign idx_byte = idx_q[7:0];
  end else begin : g_idx_narrow
    assign idx_byte = {{(8-IDX_W){1'b0}}, idx_q};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_hex
    nibble_to_ascii u_nibble_to_ascii (
      .nibble (idx_byte[gi*4 +: 4]),
      .ascii  (hex_char[gi])
    );
  end
`endif

  assign xfer = tx_valid_q & bus.tx_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    offset_d   = offset_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    error_d    = error_q;
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
    pfx_cnt_d  = pfx_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d    = cmd_idx;
          offset_d = '0;
          error_d  = NO_ERR;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if ({1'b0, idx_q} >= NUM_CMDS_W) begin
          error_d = ERR_ADDR;
          state_d = ST_DONE;
        end else begin
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
          tx_data_d  = hex_char[1];
          tx_valid_d = 1'b1;
          pfx_cnt_d  = 2'd0;
          state_d    = ST_PREFIX;
`else
          state_d = ST_RD_ISSUE;
`endif
        end
      end

`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
      // Three characters: high digit, low digit, space. The next one is
      // loaded on each transfer so tx_valid stays up across the prefix.
      ST_PREFIX: begin
        if (xfer) begin
          case (pfx_cnt_q)
            2'd0: begin
              tx_data_d = hex_char[0];
              pfx_cnt_d = 2'd1;
            end
            2'd1: begin
              tx_data_d = CHAR_SP;
              pfx_cnt_d = 2'd2;
            end
            default: begin
              tx_valid_d = 1'b0;
              state_d    = ST_RD_ISSUE;
            end
          endcase
        end
      end
`endif

      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (bus.mem_rd_data == CHAR_NUL) begin
          error_d = ERR_EMPTY;
          state_d = ST_DONE;
        end else begin
          tx_data_d  = bus.mem_rd_data;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          if (tx_data_q == CHAR_LF) begin
            state_d = ST_DONE;
          end else if (&offset_q) begin
            // Last byte of the slot went out without being LF.
            error_d = ERR_LEN;
            state_d = ST_DONE;
          end else begin
            offset_d = offset_q + 1'b1;
            state_d  = ST_RD_ISSUE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      offset_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      error_q    <= NO_ERR;
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
      pfx_cnt_q  <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      offset_q   <= offset_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      error_q    <= error_d;
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
      pfx_cnt_q  <= pfx_cnt_d;
`endif
    end
  end

  // Slot base is idx*MAX_LEN, so the address is a plain concatenation.
  assign bus.mem_rd_en   = (state_q == ST_RD_ISSUE);
  assign bus.mem_rd_addr = MEM_AW'({idx_q, offset_q});
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign error = error_q;

endmodule

// File: tb/tb_cmd_mem_reader.sv
`timescale 1ns/1ps
module tb_cmd_mem_reader;
  import cmd_mem_reader_pkg::*;

  localparam int NUM_CMDS = 16;
  localparam int IDX_W    = 5;
  localparam int MAX_LEN  = 32;
  localparam int MEM_AW   = 10;

`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
  localparam int EXP_RDEN  = 5;
  localparam int EXP_VALID = 2;
  localparam int EXP_DONE  = 17;
`else
  localparam int EXP_RDEN  = 2;
  localparam int EXP_VALID = 4;
  localparam int EXP_DONE  = 14;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] cmd_idx = '0;
  logic             busy;
  logic             done;
  cmd_tx_error_t    error;

  cmd_mem_reader_if #(.MEM_AW(MEM_AW)) bus ();

  cmd_mem_reader #(
    .NUM_CMDS (NUM_CMDS),
    .IDX_W    (IDX_W),
    .MAX_LEN  (MAX_LEN),
    .MEM_AW   (MEM_AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmd_idx (cmd_idx),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Command memory model: registered read, data valid one cycle after strobe.
  logic [7:0] mem [0:1023];
  logic [7:0] rd_data_reg = 8'h00;
  always @(posedge clk) if (bus.mem_rd_en) rd_data_reg <= mem[bus.mem_rd_addr];
  assign bus.mem_rd_data = rd_data_reg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_count = 0, tx_count = 0, done_count = 0;
  int start_cyc = 0, rd_base = 0, tx_base = 0;
  int first_rden_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
  int stall_n = 0;

  logic [7:0] exp_bytes [$];
  logic [1:0] exp_err   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tx_ready generator: stall_n == 0 means always ready, otherwise hold ready
  // low for stall_n cycles of each presented byte.
  initial begin
    int  wait_cnt;
    bit  will_xfer;
    wait_cnt = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      will_xfer = bus.tx_valid && bus.tx_ready;
      @(posedge clk);
      #1;
      if (will_xfer || !rst_n) wait_cnt = 0;
      else if (bus.tx_valid) wait_cnt++;
      bus.tx_ready = (stall_n == 0) || (bus.tx_valid && (wait_cnt > stall_n));
    end
  end

  // Monitor / scoreboard: compares every transfer and every done pulse.
  initial begin
    bit         prev_stalled;
    logic [7:0] prev_data;
    logic [7:0] e;
    logic [1:0] ee;
    prev_stalled = 1'b0;
    prev_data    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stalled = 1'b0;
      end else begin
        if (bus.mem_rd_en) begin
          rd_count++;
          if (first_rden_cyc < 0) first_rden_cyc = cyc;
        end
        if (bus.tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stalled && bus.tx_valid) check("tx_data_stable", bus.tx_data, prev_data);
        if (bus.tx_valid && bus.tx_ready) begin
          tx_count++;
          $display("tx byte 0x%02h at cycle %0d", bus.tx_data, cyc);
          if (exp_bytes.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got 0x%02h, want no byte", bus.tx_data);
          end else begin
            e = exp_bytes.pop_front();
            check("tx_byte", bus.tx_data, e);
          end
        end
        prev_stalled = bus.tx_valid && !bus.tx_ready;
        prev_data    = bus.tx_data;
        if (done) begin
          done_count++;
          done_cyc = cyc;
          $display("done error=%0d at cycle %0d", error, cyc);
          if (exp_err.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got error=%0d, want no done", error);
          end else begin
            ee = exp_err.pop_front();
            check("done_error", error, ee);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_prefix(input logic [7:0] hi, input logic [7:0] lo);
`ifdef CMD_MEM_READER_ADDR_PREFIX_EN
    exp_bytes.push_back(hi);
    exp_bytes.push_back(lo);
    exp_bytes.push_back(8'h20);
`else
    if (hi == lo) begin end
`endif
  endtask

  task automatic push_at();
    exp_bytes.push_back(8'h41);
    exp_bytes.push_back(8'h54);
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
  endtask

  task automatic send_cmd(input logic [IDX_W-1:0] idx);
    @(negedge clk);
    start          = 1'b1;
    cmd_idx        = idx;
    start_cyc      = cyc;
    rd_base        = rd_count;
    tx_base        = tx_count;
    first_rden_cyc = -1;
    first_valid_cyc = -1;
    @(negedge clk);
    start = 1'b0;
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    check({name, "_bytes_left"}, exp_bytes.size(), 0);
    check({name, "_done_left"}, exp_err.size(), 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    bit hit;
    for (int a = 0; a < 1024; a++) mem[a] = 8'h00;
    // slot 0 and slot 10: "AT\r\n"; slot 1 empty; slot 2: 32 bytes, no LF
    mem[0] = 8'h41; mem[1] = 8'h54; mem[2] = 8'h0D; mem[3] = 8'h0A;
    mem[320] = 8'h41; mem[321] = 8'h54; mem[322] = 8'h0D; mem[323] = 8'h0A;
    for (int i = 0; i < 32; i++) mem[64 + i] = 8'h30 + 8'(i);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_mem_rd_addr", bus.mem_rd_addr, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: slot 0, tx_ready high
    push_prefix(8'h30, 8'h30); push_at(); exp_err.push_back(2'd0);
    send_cmd(5'd0);
    wait_done("at_fast");
    check("at_fast_done_cycle", done_cyc - start_cyc, EXP_DONE);
    check("at_fast_rden_cycle", first_rden_cyc - start_cyc, EXP_RDEN);
    check("at_fast_valid_cycle", first_valid_cyc - start_cyc, EXP_VALID);
    check("at_fast_reads", rd_count - rd_base, 4);

    // 2: same command with backpressure; a start pulse mid-command is ignored
    stall_n = 5;
    push_prefix(8'h30, 8'h30); push_at(); exp_err.push_back(2'd0);
    send_cmd(5'd0);
    repeat (3) @(negedge clk);
    start = 1'b1; cmd_idx = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("at_stall");
    check("at_stall_reads", rd_count - rd_base, 4);
    stall_n = 0;

    // 3: out-of-range index
    exp_err.push_back(2'd1);
    send_cmd(5'd20);
    wait_done("bad_idx");
    check("bad_idx_reads", rd_count - rd_base, 0);
    check("bad_idx_tx", tx_count - tx_base, 0);

    // 4: empty slot
    push_prefix(8'h30, 8'h31); exp_err.push_back(2'd2);
    send_cmd(5'd1);
    wait_done("empty");
    check("empty_reads", rd_count - rd_base, 1);

    // 5: full slot without LF
    push_prefix(8'h30, 8'h32);
    for (int i = 0; i < 32; i++) exp_bytes.push_back(8'h30 + 8'(i));
    exp_err.push_back(2'd3);
    send_cmd(5'd2);
    wait_done("no_lf");
    check("no_lf_reads", rd_count - rd_base, 32);

    // 6: asynchronous reset while the second byte is waiting in SEND
    stall_n = 5;
    push_prefix(8'h30, 8'h30); push_at(); exp_err.push_back(2'd0);
    send_cmd(5'd0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_count - tx_base == 1 && bus.tx_valid) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", hit, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_valid", bus.tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    exp_bytes.delete();
    exp_err.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall_n = 0;
    begin
      int dc;
      dc = done_count;
      repeat (10) @(negedge clk);
      check("rst_mid_no_done", done_count - dc, 0);
      check("rst_mid_idle", busy, 0);
    end
    push_prefix(8'h30, 8'h30); push_at(); exp_err.push_back(2'd0);
    send_cmd(5'd0);
    wait_done("after_rst");
    check("after_rst_reads", rd_count - rd_base, 4);

    // 7: slot 10 (prefix build sends "0A " first)
    push_prefix(8'h30, 8'h41); push_at(); exp_err.push_back(2'd0);
    send_cmd(5'd10);
    wait_done("slot10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
